// File: rtl/lcd_pkg.sv
// lcd_pkg: panel command opcodes and controller state encoding shared by
// lcd_fill_ctrl and its tests.
package lcd_pkg;

    localparam logic [7:0] CMD_SLPOUT   = 8'h11;
    localparam logic [7:0] CMD_DISPON   = 8'h29;
    localparam logic [7:0] CMD_COLMOD   = 8'h3A;
    localparam logic [7:0] PARAM_RGB565 = 8'h55;
    localparam logic [7:0] CMD_CASET    = 8'h2A;
    localparam logic [7:0] CMD_RASET    = 8'h2B;
    localparam logic [7:0] CMD_RAMWR    = 8'h2C;

    typedef enum logic [3:0] {
        S_INIT_SLPOUT,
        S_INIT_WAIT,
        S_INIT_DISPON,
        S_INIT_COLMOD,
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR,
        S_PIXEL
    } lcd_state_e;

    function automatic logic [7:0] coord_byte(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: SPI mode-0 byte shifter; owns cs/scl/sda and releases cs only
// after a byte flagged as the last of its command group.
module spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_valid_i,
    input  logic       tx_last_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_done_o,
    output logic       cs_o,
    output logic       scl_o,
    output logic       sda_o
);

    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q;
    logic [3:0]    half_q;
    logic [7:0]    sh_q;
    logic          busy_q;
    logic          last_q;
    logic          done_q;
    logic          cs_q;
    logic          scl_q;
    logic          sda_q;
    logic          half_end;

    assign half_end = div_q == DW'(CLK_DIV - 1);

    // Sixteen half-periods per byte: even halves low, odd halves high; sda
    // advances when an odd half ends, i.e. on the falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            half_q <= '0;
            sh_q   <= '0;
            busy_q <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            cs_q   <= 1'b1;
            scl_q  <= 1'b0;
            sda_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (tx_valid_i) begin
                    busy_q <= 1'b1;
                    last_q <= tx_last_i;
                    sh_q   <= tx_data_i;
                    sda_q  <= tx_data_i[7];
                    cs_q   <= 1'b0;
                    div_q  <= '0;
                    half_q <= '0;
                end
            end else if (half_end) begin
                div_q  <= '0;
                half_q <= half_q + 4'd1;
                scl_q  <= ~half_q[0];
                if (half_q[0]) begin
                    sh_q  <= {sh_q[6:0], 1'b0};
                    sda_q <= sh_q[6];
                end
                if (half_q == 4'd15) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    cs_q   <= last_q;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign tx_done_o = done_q;
    assign cs_o      = cs_q;
    assign scl_o     = scl_q;
    assign sda_o     = sda_q;

endmodule

// File: rtl/lcd_fill_ctrl.sv
// lcd_fill_ctrl: SPI LCD init sequencer and rectangle fill engine.
// Define LCD_STREAM_EN to take pixels from a pix_valid/pix_data stream instead of color.
module lcd_fill_ctrl
    import lcd_pkg::*;
#(
    parameter int H_RES          = 240,
    parameter int V_RES          = 320,
    parameter int CLK_DIV        = 2,
    parameter int SLEEP_WAIT_CYC = 6000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [15:0] x0,
    input  logic [15:0] y0,
    input  logic [15:0] x1,
    input  logic [15:0] y1,
    input  logic [15:0] color,
    output logic        init_done,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cs,
    output logic        scl,
    output logic        sda,
    output logic        dc
`ifdef LCD_STREAM_EN
    ,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready
`endif
);

    localparam int GW = $clog2(2 * CLK_DIV + 1);

    lcd_state_e  state_q;
    logic [2:0]  idx_q;
    logic        wait_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        tx_last_q;
    logic        dc_q;
    logic [GW-1:0] gap_q;
    logic [31:0] cnt_q;
    logic [31:0] pix_left_q;
    logic [15:0] x0_q, y0_q, x1_q, y1_q, col_q;
    logic [7:0]  pix_lo_q;
    logic        fill_ready_q, init_done_q, busy_q, done_q, err_q;
    logic        tx_done;
    logic [7:0]  byte_d;
    logic        dc_d, last_d;
    logic [15:0] pix_src;
    logic        stall, sends, hi_phase, issue, req_ok;
    logic [31:0] count_d;

`ifdef LCD_STREAM_EN
    assign pix_src   = pix_data;
    assign stall     = ~pix_valid;
    assign pix_ready = hi_phase && !wait_q && gap_q == '0;
`else
    assign pix_src   = col_q;
    assign stall     = 1'b0;
`endif

    assign sends    = state_q != S_IDLE && state_q != S_INIT_WAIT;
    assign hi_phase = state_q == S_PIXEL && !idx_q[0];
    assign issue    = sends && !wait_q && gap_q == '0 && !(hi_phase && stall);
    assign req_ok   = x1 >= x0 && y1 >= y0 && 32'(x1) < 32'(H_RES) && 32'(y1) < 32'(V_RES);
    assign count_d  = (32'(x1) - 32'(x0) + 32'd1) * (32'(y1) - 32'(y0) + 32'd1);

    always_comb begin
        byte_d = 8'h00;
        dc_d   = 1'b0;
        last_d = 1'b0;
        case (state_q)
            S_INIT_SLPOUT: begin
                byte_d = CMD_SLPOUT;
                last_d = 1'b1;
            end
            S_INIT_DISPON: begin
                byte_d = CMD_DISPON;
                last_d = 1'b1;
            end
            S_INIT_COLMOD: begin
                byte_d = idx_q[0] ? PARAM_RGB565 : CMD_COLMOD;
                dc_d   = idx_q[0];
                last_d = idx_q[0];
            end
            S_CASET: begin
                byte_d = idx_q == 3'd0 ? CMD_CASET : coord_byte(idx_q >= 3'd3 ? x1_q : x0_q, idx_q[0]);
                dc_d   = idx_q != 3'd0;
                last_d = idx_q == 3'd4;
            end
            S_RASET: begin
                byte_d = idx_q == 3'd0 ? CMD_RASET : coord_byte(idx_q >= 3'd3 ? y1_q : y0_q, idx_q[0]);
                dc_d   = idx_q != 3'd0;
                last_d = idx_q == 3'd4;
            end
            S_RAMWR: byte_d = CMD_RAMWR;
            S_PIXEL: begin
                byte_d = idx_q[0] ? pix_lo_q : pix_src[15:8];
                dc_d   = 1'b1;
                last_d = idx_q[0] && pix_left_q == 32'd1;
            end
            default: ;
        endcase
    end

    // Each byte is issued once, then the sequencer waits for the shifter's done
    // pulse before advancing; cs gaps are timed from the end of a group.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_INIT_SLPOUT;
            idx_q        <= '0;
            wait_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_last_q    <= 1'b0;
            dc_q         <= 1'b0;
            gap_q        <= '0;
            cnt_q        <= '0;
            pix_left_q   <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            col_q        <= '0;
            pix_lo_q     <= '0;
            fill_ready_q <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            if (state_q != S_IDLE) busy_q <= 1'b1;
            if (gap_q != '0) gap_q <= gap_q - 1'b1;
            if (issue) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= byte_d;
                tx_last_q  <= last_d;
                dc_q       <= dc_d;
                wait_q     <= 1'b1;
                if (hi_phase) pix_lo_q <= pix_src[7:0];
            end
            if (tx_done) begin
                wait_q <= 1'b0;
                idx_q  <= idx_q + 3'd1;
                if (tx_last_q) gap_q <= GW'(2 * CLK_DIV);
                case (state_q)
                    S_INIT_SLPOUT: begin
                        state_q <= S_INIT_WAIT;
                        cnt_q   <= '0;
                    end
                    S_INIT_DISPON: begin
                        state_q <= S_INIT_COLMOD;
                        idx_q   <= '0;
                    end
                    S_INIT_COLMOD: if (idx_q[0]) begin
                        state_q      <= S_IDLE;
                        init_done_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        fill_ready_q <= 1'b1;
                    end
                    S_CASET: if (idx_q == 3'd4) begin
                        state_q <= S_RASET;
                        idx_q   <= '0;
                    end
                    S_RASET: if (idx_q == 3'd4) begin
                        state_q <= S_RAMWR;
                        idx_q   <= '0;
                    end
                    S_RAMWR: begin
                        state_q <= S_PIXEL;
                        idx_q   <= '0;
                    end
                    S_PIXEL: if (idx_q[0]) begin
                        idx_q      <= '0;
                        pix_left_q <= pix_left_q - 32'd1;
                        if (pix_left_q == 32'd1) begin
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            fill_ready_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state_q == S_INIT_WAIT) begin
                cnt_q <= cnt_q + 32'd1;
                if (cnt_q + 32'd1 >= 32'(SLEEP_WAIT_CYC)) state_q <= S_INIT_DISPON;
            end
            if (fill_ready_q && fill_valid) begin
                x0_q  <= x0;
                y0_q  <= y0;
                x1_q  <= x1;
                y1_q  <= y1;
                col_q <= color;
                if (req_ok) begin
                    state_q      <= S_CASET;
                    idx_q        <= '0;
                    busy_q       <= 1'b1;
                    fill_ready_q <= 1'b0;
                    pix_left_q   <= count_d;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_valid_i (tx_valid_q),
        .tx_last_i  (tx_last_q),
        .tx_data_i  (tx_data_q),
        .tx_done_o  (tx_done),
        .cs_o       (cs),
        .scl_o      (scl),
        .sda_o      (sda)
    );

    assign fill_ready = fill_ready_q;
    assign init_done  = init_done_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dc         = dc_q;

endmodule

// File: doc/lcd_fill_ctrl.md
LCD_FILL_CTRL -- requirements
Module: lcd_fill_ctrl

Interface
REQ-001 SHALL take parameter H_RES, default 240, panel width in pixels.
REQ-002 SHALL take parameter V_RES, default 320, panel height in pixels.
REQ-003 SHALL take parameter CLK_DIV, default 2, clk cycles per SCL half-period, legal range >=1.
REQ-004 SHALL take parameter SLEEP_WAIT_CYC, default 6000000, clk cycles waited after SLPOUT.
REQ-005 SHALL have ports, one per line:
 clk  in  1  system clock; all logic on rising edge
 reset_n  in  1  reset
 fill_valid  in  1  fill request
 fill_ready  out  1  request accepted when fill_valid & fill_ready
 x0, y0, x1, y1  in  16 each  inclusive rectangle corners
 color  in  16  RGB565 fill colour
 init_done  out  1  panel init sequence complete
 busy  out  1  transfer in progress
 done  out  1  one-cycle pulse at end of fill
 err  out  1  one-cycle pulse on rejected request
 cs  out  1  SPI chip select, active low
 scl  out  1  SPI clock
 sda  out  1  SPI data
 dc  out  1  0 = command byte, 1 = data byte
REQ-006 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-007 SHALL drive SPI mode 0: scl idle low, sda MSB first, sda changes on scl falling edge, byte = 16*CLK_DIV clk cycles.
REQ-008 SHALL hold dc stable for all 8 bits of a byte and cs low for a whole command plus its parameter/pixel bytes.
REQ-009 SHALL deassert cs for at least 2*CLK_DIV cycles between command groups.
REQ-010 SHALL after reset run states INIT_SLPOUT (0x11) -> INIT_WAIT (SLEEP_WAIT_CYC cycles) -> INIT_DISPON (0x29) -> INIT_COLMOD (0x3A, data 0x55) -> IDLE, then set init_done=1.
REQ-011 SHALL hold fill_ready=1 only in IDLE with init_done=1, and capture all request fields on the accepting cycle.
REQ-012 SHALL reject requests with x1<x0, y1<y0, x1>=H_RES or y1>=V_RES: pulse err one cycle after acceptance, send nothing, stay IDLE.
REQ-013 SHALL on a valid request send CASET 0x2A + x0[15:8],x0[7:0],x1[15:8],x1[7:0]; RASET 0x2B + same for y; RAMWR 0x2C; then (x1-x0+1)*(y1-y0+1) pixels, each colour[15:8] then colour[7:0], dc=1.
REQ-014 SHALL compute pixel count in 32-bit unsigned arithmetic; a 1x1 rectangle sends exactly 2 pixel bytes.
REQ-015 SHALL pulse done one cycle after the last pixel byte's final scl falling edge with cs high, then return to IDLE, busy=0.
REQ-016 SHALL keep busy=1 from acceptance to done, and during the init sequence.
REQ-017 SHALL ignore fill_valid while busy; no queuing.

Reset
REQ-018 SHALL on reset_n low force cs=1, scl=0, sda=0, dc=0, fill_ready=0, init_done=0, busy=0, done=0, err=0, and clear all counters.
REQ-019 SHALL on reset mid-transfer abort immediately (cs high within the reset) and rerun the full init sequence after release.

Configuration
REQ-020 SHALL with LCD_STREAM_EN defined add ports pix_valid (in,1), pix_data (in,16), pix_ready (out,1) and source each pixel from the stream, stalling scl with cs low while pix_valid=0; color is then ignored.
REQ-021 SHALL without LCD_STREAM_EN have no stream ports and send constant color.

Structure
REQ-022 SHALL place command opcodes (0x11, 0x29, 0x3A, 0x55, 0x2A, 0x2B, 0x2C) and the state enumeration in shared package lcd_pkg.
REQ-023 SHALL instantiate one sub-module spi_byte_tx (byte-in/valid, done pulse, cs/scl/sda generation, CLK_DIV parameter).

Verification
REQ-024 Reset release, SLEEP_WAIT_CYC=100, CLK_DIV=1 -> bytes 0x11(dc0), 0x29(dc0), 0x3A(dc0), 0x55(dc1) decoded; init_done rises.
REQ-025 Fill x0=0,y0=0,x1=1,y1=1,color=0xF800 -> CASET 00 00 00 01, RASET 00 00 00 01, 0x2C, then F8 00 x4; one done pulse.
REQ-026 Fill x1=240 with H_RES=240 -> err pulse, no cs activity, fill_ready stays 1.
REQ-027 fill_valid held during busy with different color -> second request not taken until done; only first colour on sda.
REQ-028 reset_n low mid-pixel stream -> cs=1 immediately; after release init bytes 0x11 first.
REQ-029 With LCD_STREAM_EN, pix_valid low 50 cycles mid-fill -> scl static, cs low, no bytes lost; pixel order matches stream.
